// File: rtl/mem_accum_pkg.sv
// Shared definitions for the memory-reduction engine: FSM state encoding
// and accumulation mode constants.
package mem_accum_pkg;

  // Job sequencing states of the engine.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Accumulation modes selected by the Mode input.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/mem_accum_engine_accum_unit.sv
// Accumulator datapath: DATA_W+1-bit adder, wrap or saturate result
// selection and a sticky carry flag. Cleared at the start of every job.
module accum_unit
  import mem_accum_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              mode,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc,
  output logic              overflow
);

  logic [DATA_W:0] total;

  // Widened add so the carry out of the word is visible.
  always_comb total = {1'b0, acc} + {1'b0, din};

  // Accumulator and sticky carry; once saturated, every further add either
  // carries again or adds zero, so the value stays at all-ones.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (load) begin
      overflow <= overflow | total[DATA_W];
      if (mode == MODE_WRAP) begin
        acc <= total[DATA_W-1:0];
      end else begin
        acc <= total[DATA_W] ? '1 : total[DATA_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_accum_engine.sv
// Memory-reduction engine: on an accepted Start it reads Count words from a
// synchronous single-port memory starting at BaseAddr (wrapping), sums them
// in wrap or saturate mode, writes the sum to DestAddr and pulses Done.
module mem_accum_engine
  import mem_accum_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  input  logic [ADDR_W-1:0] DestAddr,
  input  logic              Mode,
  output logic              Ready,
  output logic              Done,
  output logic              Overflow,
  output logic [DATA_W-1:0] Sum,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  input  logic [DATA_W-1:0] DataOut
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state, state_next;
  logic [ADDR_W-1:0]   base_q, dest_q;
  logic [ADDR_W:0]     len_q, idx;
  logic                mode_q;
  logic [RD_LAT-1:0]   vld, vld_next;
  logic [DATA_W-1:0]   sum_q, acc;
  logic [ADDR_W:0]     count_clamped;
  logic                accept;

  // Requests beyond the memory depth read every word exactly once.
  always_comb count_clamped = (Count > DEPTH) ? DEPTH : Count;

  // Start is honoured only while idle; there is no request queue.
  always_comb accept = (state == IDLE) && Start;

  // In-flight read tracker: bit k set means a read issued k+1 cycles ago.
  // Its top bit marks the cycle in which that read's data is on DataOut.
  always_comb vld_next = RD_LAT'({vld, ReadEnable});

  // Job sequencing.
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = (count_clamped == '0) ? WRITE : READ;
      READ:    if (idx == len_q - ONE) state_next = DRAIN;
      DRAIN:   if (vld_next == '0) state_next = WRITE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, job parameters latched at Start, read index, tracker, result.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      base_q <= '0;
      dest_q <= '0;
      len_q  <= '0;
      mode_q <= MODE_WRAP;
      idx    <= '0;
      vld    <= '0;
      sum_q  <= '0;
    end else begin
      state <= state_next;
      vld   <= vld_next;
      if (accept) begin
        base_q <= BaseAddr;
        dest_q <= DestAddr;
        len_q  <= count_clamped;
        mode_q <= Mode;
        idx    <= '0;
      end else if (state == READ) begin
        idx <= idx + ONE;
      end
      if (state == WRITE) sum_q <= acc;
    end
  end

  accum_unit #(
    .DATA_W (DATA_W)
  ) u_accum (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (accept),
    .load     (vld[RD_LAT-1]),
    .mode     (mode_q),
    .din      (DataOut),
    .acc      (acc),
    .overflow (Overflow)
  );

  // Memory pins and status decoded from the current state.
  always_comb begin
    Ready       = (state == IDLE);
    Done        = (state == DONE);
    ReadEnable  = (state == READ);
    WriteEnable = (state == WRITE);
    Address     = '0;
    DataIN      = '0;
    if (state == READ) begin
      Address = base_q + idx[ADDR_W-1:0];
    end else if (state == WRITE) begin
      Address = dest_q;
      DataIN  = acc;
    end
  end

  always_comb Sum = sum_q;

endmodule
